// File: rtl/cosine_sim_pkg.sv
// cosine_sim_pkg
//   Shared types for the cosine similarity engine and its front-end feeder.
//   status_t       : result status code returned with every similarity.
//   feeder_state_t : state encoding of the feeder sequencer.

package cosine_sim_pkg;

    typedef enum logic [1:0] {
        ST_OK        = 2'b00,
        ST_LEN_SHORT = 2'b01,
        ST_LEN_LONG  = 2'b10,
        ST_TIMEOUT   = 2'b11
    } status_t;

    typedef enum logic [2:0] {
        FS_LOAD  = 3'd0,
        FS_DRAIN = 3'd1,
        FS_FIRE  = 3'd2,
        FS_WAIT  = 3'd3,
        FS_RESP  = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/cosine_vec_buf.sv
// cosine_vec_buf
//   W-slot dual 32-bit register file. One slot of each vector is written per
//   cycle when i_we is high; both complete vectors are always visible.
//   Ports:
//     i_clk, i_rst        clock, synchronous active-high reset (clears all slots)
//     i_we, i_idx         write enable and slot index
//     i_a, i_b            data written to vector A / vector B slot i_idx
//     o_vec_a, o_vec_b    full vector contents, unpacked [W-1:0]

module cosine_vec_buf
    import cosine_sim_pkg::*;
#(
    parameter int W  = 5,
    parameter int IW = $clog2(W + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_we,
    input  logic [IW-1:0]   i_idx,
    input  logic [31:0]     i_a,
    input  logic [31:0]     i_b,
    output logic [31:0]     o_vec_a [W-1:0],
    output logic [31:0]     o_vec_b [W-1:0]
);

    localparam logic [IW-1:0] MAX_IDX = IW'(W - 1);

    logic [31:0] r_a [W-1:0];
    logic [31:0] r_b [W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < W; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
        end else if (i_we && (i_idx <= MAX_IDX)) begin
            r_a[i_idx] <= i_a;
            r_b[i_idx] <= i_b;
        end
    end

    assign o_vec_a = r_a;
    assign o_vec_b = r_b;

endmodule

// File: rtl/cosine_sim_feeder.sv
// cosine_sim_feeder
//   Initiator side of the cosine_sim engine. Collects FP32 element pairs from
//   a valid/ready stream into W-wide vectors, fires one engine computation,
//   waits for the engine result under a timeout and returns the similarity
//   with a status code on a valid/ready result port.
//   Ports:
//     i_clk, i_rst                           clock, synchronous active-high reset
//     i_in_valid/o_in_ready/i_in_a/i_in_b/i_in_last   element pair stream
//     o_eng_start                            one-cycle engine start pulse
//     o_eng_vec_a, o_eng_vec_b               assembled vectors to the engine
//     i_eng_similarity, i_eng_valid          engine result
//     o_out_valid/i_out_ready                result handshake
//     o_out_similarity, o_out_status         captured result (0 on error) and status
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   LOAD  | accept beats into slot cnt; decide FIRE / short / overflow
//   DRAIN | vector too long: discard beats until in_last
//   FIRE  | one-cycle engine start, timer cleared
//   WAIT  | wait for engine valid or timeout
//   RESP  | hold result until consumed

module cosine_sim_feeder
    import cosine_sim_pkg::*;
#(
    parameter int W       = 5,
    parameter int TIMEOUT = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [31:0]     i_in_a,
    input  logic [31:0]     i_in_b,
    input  logic            i_in_last,
    output logic            o_eng_start,
    output logic [31:0]     o_eng_vec_a [W-1:0],
    output logic [31:0]     o_eng_vec_b [W-1:0],
    input  logic [31:0]     i_eng_similarity,
    input  logic            i_eng_valid,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [31:0]     o_out_similarity,
    output logic [1:0]      o_out_status
);

    localparam int CW = $clog2(W + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0] LAST_IDX   = CW'(W - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] S_LOAD  = FS_LOAD;
    localparam logic [2:0] S_DRAIN = FS_DRAIN;
    localparam logic [2:0] S_FIRE  = FS_FIRE;
    localparam logic [2:0] S_WAIT  = FS_WAIT;
    localparam logic [2:0] S_RESP  = FS_RESP;

    logic [2:0]     r_state;
    logic [CW-1:0]  r_cnt;
    logic [TW-1:0]  r_timer;
    logic [31:0]    r_similarity;
    logic [1:0]     r_status;

    logic           w_accept;
    logic           w_load_beat;

    // Handshake outputs decode only from the state register.
    assign o_in_ready  = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign o_out_valid = (r_state == S_RESP);
    assign o_eng_start = (r_state == S_FIRE);

    assign w_accept    = i_in_valid && o_in_ready;
    assign w_load_beat = w_accept && (r_state == S_LOAD);

    assign o_out_similarity = r_similarity;
    assign o_out_status     = r_status;

    // Slots are only written in LOAD, so the vectors stay frozen while the
    // engine is reading them in FIRE and WAIT.
    cosine_vec_buf #(
        .W  (W),
        .IW (CW)
    ) u_vec_buf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_load_beat),
        .i_idx   (r_cnt),
        .i_a     (i_in_a),
        .i_b     (i_in_b),
        .o_vec_a (o_eng_vec_a),
        .o_vec_b (o_eng_vec_b)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_LOAD;
            r_cnt        <= '0;
            r_timer      <= '0;
            r_similarity <= '0;
            r_status     <= ST_OK;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (i_in_last) begin
                            if (r_cnt == LAST_IDX) begin
                                r_state <= S_FIRE;
                            end else begin
                                r_state      <= S_RESP;
                                r_status     <= ST_LEN_SHORT;
                                r_similarity <= '0;
                            end
                        end else if (r_cnt == LAST_IDX) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_accept && i_in_last) begin
                        r_state      <= S_RESP;
                        r_status     <= ST_LEN_LONG;
                        r_similarity <= '0;
                    end
                end
                S_FIRE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Engine valid takes priority over an expiring timer.
                    if (i_eng_valid) begin
                        r_similarity <= i_eng_similarity;
                        r_status     <= ST_OK;
                        r_state      <= S_RESP;
                    end else if (r_timer == TIMER_LAST) begin
                        r_similarity <= '0;
                        r_status     <= ST_TIMEOUT;
                        r_state      <= S_RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RESP: begin
                    if (i_out_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_LOAD;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cosine_sim_feeder.sv
// tb_cosine_sim_feeder
//   Self-checking bench for cosine_sim_feeder: a table of hand-computed
//   transactions, a randomized run against a transaction-level model, and
//   hand-written reset and backpressure sequences.

module tb_cosine_sim_feeder;

    localparam int W  = 5;
    localparam int TO = 64;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_last;
    logic        eng_start;
    logic [31:0] eng_vec_a [W-1:0];
    logic [31:0] eng_vec_b [W-1:0];
    logic [31:0] eng_sim;
    logic        eng_valid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sim;
    logic [1:0]  out_status;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Engine model controls and observations.
    int          eng_delay   = 0;
    logic [31:0] eng_result  = '0;
    int          eng_pend    = 0;
    int          start_count = 0;
    int          fire_cyc    = -1;

    logic [31:0] va [16];
    logic [31:0] vb [16];

    typedef struct {
        int          beats;
        int          delay;
        logic [31:0] res;
        int          hold;
        bit          rnd;
        logic [1:0]  st;
        logic [31:0] sim;
        bit          start;
        int          lat;
    } vec_t;

    vec_t tbl [11];

    cosine_sim_feeder #(
        .W       (W),
        .TIMEOUT (TO)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_in_valid       (in_valid),
        .o_in_ready       (in_ready),
        .i_in_a           (in_a),
        .i_in_b           (in_b),
        .i_in_last        (in_last),
        .o_eng_start      (eng_start),
        .o_eng_vec_a      (eng_vec_a),
        .o_eng_vec_b      (eng_vec_b),
        .i_eng_similarity (eng_sim),
        .i_eng_valid      (eng_valid),
        .o_out_valid      (out_valid),
        .i_out_ready      (out_ready),
        .o_out_similarity (out_sim),
        .o_out_status     (out_status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Engine: pulses eng_valid 'eng_delay' cycles after seeing eng_start
    // (0 = silent). Between pulses the result bus carries junk.
    initial begin
        eng_valid = 1'b0;
        eng_sim   = '0;
        forever begin
            @(negedge clk);
            eng_valid = 1'b0;
            eng_sim   = $urandom;
            if (eng_pend > 0) begin
                eng_pend--;
                if (eng_pend == 0) begin
                    eng_valid = 1'b1;
                    eng_sim   = eng_result;
                end
            end
            if (eng_start) begin
                start_count++;
                fire_cyc = cyc;
                if (eng_delay > 0) eng_pend = eng_delay;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Transaction-level expectation: length decides error codes, otherwise
    // the engine delay decides OK vs timeout.
    function automatic void model(input int beats, input int delay, input logic [31:0] res,
                                  output logic [1:0] st, output logic [31:0] sim,
                                  output bit start, output int lat);
        if (beats < W) begin
            st = 2'b01; sim = '0; start = 1'b0; lat = 1;
        end else if (beats > W) begin
            st = 2'b10; sim = '0; start = 1'b0; lat = 1;
        end else if (delay >= 1 && delay <= TO) begin
            st = 2'b00; sim = res; start = 1'b1; lat = delay + 2;
        end else begin
            st = 2'b11; sim = '0; start = 1'b1; lat = TO + 2;
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        logic [31:0] orv;
        orv = '0;
        for (int i = 0; i < W; i++) orv = orv | eng_vec_a[i] | eng_vec_b[i];
        chk({tag, "_in_ready"},  64'(in_ready),   64'(1));
        chk({tag, "_out_valid"}, 64'(out_valid),  64'(0));
        chk({tag, "_eng_start"}, 64'(eng_start),  64'(0));
        chk({tag, "_out_sim"},   64'(out_sim),    64'(0));
        chk({tag, "_status"},    64'(out_status), 64'(0));
        chk({tag, "_vec_zero"},  64'(orv),        64'(0));
    endtask

    // Called at a falling edge; returns at a falling edge with in_valid low.
    task automatic send(input int beats, input bit rnd, input bit gaps, output int n_cyc);
        int guard;
        n_cyc = -1;
        for (int i = 0; i < beats; i++) begin
            guard = 0;
            if (gaps) begin
                while ($urandom_range(0, 3) == 0 && guard < 4) begin
                    in_valid = 1'b0;
                    guard++;
                    @(negedge clk);
                end
            end
            guard = 0;
            while (!in_ready && guard < 200) begin
                in_valid = 1'b0;
                guard++;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_last  = (i == beats - 1);
            in_a     = rnd ? $urandom : 32'h3F80_0000;
            in_b     = rnd ? $urandom : 32'h3F80_0000;
            if (i < 16) begin
                va[i] = in_a;
                vb[i] = in_b;
            end
            n_cyc = cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input bit junk, output int r_cyc);
        r_cyc = -1;
        for (int k = 0; k < 200; k++) begin
            if (out_valid) begin
                r_cyc = cyc;
                break;
            end
            if (junk) begin
                in_valid = 1'($urandom_range(0, 1));
                in_last  = 1'($urandom_range(0, 1));
                in_a     = $urandom;
                in_b     = $urandom;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume(input int hold, input logic [31:0] sim, input logic [1:0] st);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            chk("hold_out_valid", 64'(out_valid),  64'(1));
            chk("hold_sim",       64'(out_sim),    64'(sim));
            chk("hold_status",    64'(out_status), 64'(st));
            chk("hold_in_ready",  64'(in_ready),   64'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_in_ready",  64'(in_ready),  64'(1));
        chk("post_hs_out_valid", 64'(out_valid), 64'(0));
    endtask

    task automatic run_vec(input int beats, input int delay, input logic [31:0] res,
                           input int hold, input bit rnd, input bit gaps, input bit junk,
                           input logic [1:0] st, input logic [31:0] sim,
                           input bit start, input int lat);
        int sc0;
        int n_cyc;
        int r_cyc;
        sc0        = start_count;
        eng_delay  = delay;
        eng_result = res;
        fire_cyc   = -1;
        send(beats, rnd, gaps, n_cyc);
        wait_result(junk, r_cyc);
        chk("latency", 64'(r_cyc - n_cyc), 64'(lat));
        if (r_cyc >= 0) begin
            chk("status", 64'(out_status), 64'(st));
            chk("sim",    64'(out_sim),    64'(sim));
            if (start) begin
                chk("fire_cycle", 64'(fire_cyc), 64'(n_cyc + 1));
                for (int i = 0; i < W; i++) begin
                    chk("vec_a", 64'(eng_vec_a[i]), 64'(va[i]));
                    chk("vec_b", 64'(eng_vec_b[i]), 64'(vb[i]));
                end
            end
            consume(hold, sim, st);
        end
        chk("start_pulses", 64'(start_count - sc0), 64'(start));
    endtask

    initial begin
        logic [1:0]  m_st;
        logic [31:0] m_sim;
        bit          m_start;
        int          m_lat;
        int          beats;
        int          delay;
        logic [31:0] res;
        int          n_cyc;
        int          guard;

        tbl[0]  = '{5, 20, 32'h3F80_0000, 10, 1'b0, 2'b00, 32'h3F80_0000, 1'b1, 22};
        tbl[1]  = '{3, 20, 32'h1234_5678,  0, 1'b1, 2'b01, 32'h0,         1'b0,  1};
        tbl[2]  = '{7, 20, 32'h1234_5678,  2, 1'b1, 2'b10, 32'h0,         1'b0,  1};
        tbl[3]  = '{5, 20, 32'h3F35_04F3,  0, 1'b1, 2'b00, 32'h3F35_04F3, 1'b1, 22};
        tbl[4]  = '{5,  0, 32'h4000_0000,  1, 1'b1, 2'b11, 32'h0,         1'b1, 66};
        tbl[5]  = '{5, 64, 32'h3F00_0000,  0, 1'b1, 2'b00, 32'h3F00_0000, 1'b1, 66};
        tbl[6]  = '{1, 20, 32'h1111_1111,  0, 1'b1, 2'b01, 32'h0,         1'b0,  1};
        tbl[7]  = '{4, 20, 32'h2222_2222,  3, 1'b1, 2'b01, 32'h0,         1'b0,  1};
        tbl[8]  = '{6, 20, 32'h3333_3333,  0, 1'b1, 2'b10, 32'h0,         1'b0,  1};
        tbl[9]  = '{5,  1, 32'h3E80_0000,  0, 1'b1, 2'b00, 32'h3E80_0000, 1'b1,  3};
        tbl[10] = '{5, 63, 32'hBF80_0000,  0, 1'b1, 2'b00, 32'hBF80_0000, 1'b1, 65};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_reset");

        for (int t = 0; t < 11; t++) begin
            run_vec(tbl[t].beats, tbl[t].delay, tbl[t].res, tbl[t].hold, tbl[t].rnd,
                    1'b0, 1'b0, tbl[t].st, tbl[t].sim, tbl[t].start, tbl[t].lat);
        end

        for (int t = 0; t < 40; t++) begin
            beats = $urandom_range(1, 8);
            delay = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
            res   = $urandom;
            model(beats, delay, res, m_st, m_sim, m_start, m_lat);
            run_vec(beats, delay, res, $urandom_range(0, 3), 1'b1, 1'b1, 1'b1,
                    m_st, m_sim, m_start, m_lat);
        end

        // Leave a nonzero result behind so the reset clearing is visible.
        run_vec(5, 4, 32'h3E00_0000, 0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h3E00_0000, 1'b1, 6);

        // Reset five cycles into the engine computation; the late eng_valid
        // then lands in LOAD and must be ignored.
        eng_delay  = 10;
        eng_result = 32'h3F80_0000;
        send(5, 1'b1, 1'b0, n_cyc);
        guard = 0;
        while (cyc < n_cyc + 6 && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            chk("rst_wait_out_valid", 64'(out_valid), 64'(0));
            chk("rst_wait_in_ready",  64'(in_ready),  64'(1));
            @(negedge clk);
        end
        check_reset_outputs("mid_wait_reset");

        run_vec(5, 20, 32'h3F80_0000, 0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h3F80_0000, 1'b1, 22);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
